// File: rtl/frame_link_ctrl_if.sv
// frame_link_ctrl_if: request, serial line, analyser reply and response
// signals of the frame link controller bundled into one interface.
//   master : request/reply source (upstream logic plus external analyser)
//   slave  : frame_link_ctrl itself
// Signals:
//   req_valid/req_ready/req_mode/req_type/req_data : request handshake
//   write/read/dout/rx_listen                      : line and window control
//   rx_valid/rx_data/rx_check_ok                   : decoded analyser reply
//   resp_valid/resp_data/resp_status/retry_cnt     : response to upstream
interface frame_link_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_mode;
    logic [1:0]        req_type;
    logic [DATA_W-1:0] req_data;
    logic              write;
    logic              read;
    logic              dout;
    logic              rx_listen;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_check_ok;
    logic              resp_valid;
    logic [7:0]        resp_data;
    logic [1:0]        resp_status;
    logic [1:0]        retry_cnt;

    modport master (
        output req_valid, req_mode, req_type, req_data,
        output rx_valid, rx_data, rx_check_ok,
        input  req_ready, write, read, dout, rx_listen,
        input  resp_valid, resp_data, resp_status, retry_cnt
    );

    modport slave (
        input  req_valid, req_mode, req_type, req_data,
        input  rx_valid, rx_data, rx_check_ok,
        output req_ready, write, read, dout, rx_listen,
        output resp_valid, resp_data, resp_status, retry_cnt
    );
endinterface

// File: rtl/frame_link_ctrl.sv
// frame_link_ctrl: single-wire command/response link controller.
// Serialises a framed request MSB first on dout (BIT_PERIOD cycles per bit),
// then opens a receive window (blind interval, then listen) bounded by a
// timeout, and returns the analyser reply or an error status. Timeouts and
// checksum failures retransmit the same frame up to MAX_RETRIES times.
// Ports:
//   clk    : system clock
//   nrst   : synchronous active-low reset
//   enable : link enable; low behaves exactly like reset
//   link   : frame_link_ctrl_if slave modport (request, line, reply, response)
module frame_link_ctrl #(
    parameter int DATA_W         = 16,
    parameter int BIT_PERIOD     = 200000,
    parameter int BLIND_CYCLES   = 2000000,
    parameter int TIMEOUT_CYCLES = 10000000,
    parameter int MAX_RETRIES    = 2,
    parameter int CNT_W          = 24
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   enable,
    frame_link_ctrl_if.slave       link
);
    localparam int FRAME_W = DATA_W + 20;
    localparam int IDX_W   = $clog2(FRAME_W);

    localparam logic [IDX_W-1:0] LAST_BIT   = IDX_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] BP_LAST    = CNT_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] BLIND_LAST = CNT_W'(BLIND_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO        = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [1:0]       MAX_R      = 2'(MAX_RETRIES);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_CHKFAIL = 2'b10;

    typedef enum logic [2:0] {IDLE, TX, BLIND, LISTEN, RESP} state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d, frame_new;
    logic [IDX_W-1:0]   bit_q, bit_d;
    logic [CNT_W-1:0]   bcnt_q, bcnt_d;
    logic [CNT_W-1:0]   tcnt_q, tcnt_d;
    logic               write_q, write_d;
    logic               read_q, read_d;
    logic               dout_q, dout_d;
    logic               listen_q, listen_d;
    logic               resp_valid_q, resp_valid_d;
    logic [7:0]         resp_data_q, resp_data_d;
    logic [1:0]         resp_status_q, resp_status_d;
    logic [1:0]         retry_q, retry_d;
    logic               run, accept, fail;
    logic [1:0]         fail_status;

    assign run            = nrst & enable;
    assign link.req_ready = run && (state_q == IDLE);
    assign accept         = link.req_valid && link.req_ready;

    // Dual-rail fields carry the complement first, then the true bit.
    assign frame_new = {6'b101010,
                        ~link.req_mode[1], link.req_mode[1],
                        ~link.req_mode[0], link.req_mode[0],
                        ~link.req_type[1], link.req_type[1],
                        ~link.req_type[0], link.req_type[0],
                        link.req_data,
                        ~^link.req_data, ^link.req_data,
                        4'b0101};

    assign link.write       = write_q;
    assign link.read        = read_q;
    assign link.dout        = dout_q;
    assign link.rx_listen   = listen_q;
    assign link.resp_valid  = resp_valid_q;
    assign link.resp_data   = resp_data_q;
    assign link.resp_status = resp_status_q;
    assign link.retry_cnt   = retry_q;

    always_ff @(posedge clk) begin
        if (!run) begin
            state_q       <= IDLE;
            frame_q       <= '0;
            bit_q         <= '0;
            bcnt_q        <= '0;
            tcnt_q        <= '0;
            write_q       <= 1'b0;
            read_q        <= 1'b0;
            dout_q        <= 1'b0;
            listen_q      <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
            resp_status_q <= '0;
            retry_q       <= '0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            bit_q         <= bit_d;
            bcnt_q        <= bcnt_d;
            tcnt_q        <= tcnt_d;
            write_q       <= write_d;
            read_q        <= read_d;
            dout_q        <= dout_d;
            listen_q      <= listen_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
            resp_status_q <= resp_status_d;
            retry_q       <= retry_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        bit_d         = bit_q;
        bcnt_d        = bcnt_q;
        tcnt_d        = tcnt_q;
        write_d       = write_q;
        read_d        = read_q;
        dout_d        = dout_q;
        listen_d      = listen_q;
        resp_valid_d  = 1'b0;
        resp_data_d   = resp_data_q;
        resp_status_d = resp_status_q;
        retry_d       = retry_q;
        fail          = 1'b0;
        fail_status   = ST_TIMEOUT;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = TX;
                    frame_d = frame_new;
                    bit_d   = '0;
                    bcnt_d  = '0;
                    write_d = 1'b1;
                    dout_d  = frame_new[FRAME_W-1];
                    retry_d = '0;
                end
            end
            TX: begin
                if (bcnt_q == BP_LAST) begin
                    bcnt_d = '0;
                    if (bit_q == LAST_BIT) begin
                        state_d = BLIND;
                        write_d = 1'b0;
                        dout_d  = 1'b0;
                        read_d  = 1'b1;
                        tcnt_d  = '0;
                    end else begin
                        bit_d  = bit_q + IDX_W'(1);
                        dout_d = frame_q[LAST_BIT - bit_d];
                    end
                end else begin
                    bcnt_d = bcnt_q + CNT_W'(1);
                end
            end
            BLIND: begin
                // Timeout counter already runs here; replies are ignored.
                tcnt_d = tcnt_q + CNT_W'(1);
                if (tcnt_q == BLIND_LAST) begin
                    state_d  = LISTEN;
                    listen_d = 1'b1;
                end
            end
            LISTEN: begin
                tcnt_d = tcnt_q + CNT_W'(1);
                // A reply on the expiry cycle takes priority over the timeout.
                if (link.rx_valid) begin
                    if (link.rx_check_ok) begin
                        state_d       = RESP;
                        resp_valid_d  = 1'b1;
                        resp_data_d   = link.rx_data;
                        resp_status_d = ST_OK;
                        read_d        = 1'b0;
                        listen_d      = 1'b0;
                    end else begin
                        fail        = 1'b1;
                        fail_status = ST_CHKFAIL;
                    end
                end else if (tcnt_q == TMO) begin
                    fail        = 1'b1;
                    fail_status = ST_TIMEOUT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fail) begin
            read_d   = 1'b0;
            listen_d = 1'b0;
            if (retry_q < MAX_R) begin
                // Retransmit the latched frame from its MSB.
                retry_d = retry_q + 2'd1;
                state_d = TX;
                bit_d   = '0;
                bcnt_d  = '0;
                write_d = 1'b1;
                dout_d  = frame_q[FRAME_W-1];
            end else begin
                state_d       = RESP;
                resp_valid_d  = 1'b1;
                resp_data_d   = '0;
                resp_status_d = fail_status;
            end
        end
    end
endmodule
